// File: rtl/seq_shift_mult_if.sv
// Operand/result bundle for the shift-add multiplier.
// The requester drives start/A/B; the multiplier returns busy/done/P.
interface seq_shift_mult_if #(
  parameter int N = 16
);
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;

  modport master (output start, A, B, input busy, done, P);
  modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/seq_shift_mult.sv
// Iterative unsigned shift-add multiplier: N compute cycles per product.
// P is a holding register that only changes when a new result completes.
module seq_shift_mult #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_shift_mult_if.slave   bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q;
  logic [N-1:0]   mcand_q;
  logic [2*N:0]   acc_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] p_q;
  logic           busy_q;
  logic           done_q;

  logic [N:0]     sum_d;
  logic [2*N:0]   acc_d;
  logic           last_step_d;

  // Add into the upper half with one extra bit so the carry survives the shift.
  always_comb begin
    sum_d       = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    acc_d       = {sum_d, acc_q[N-1:0]} >> 1;
    last_step_d = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q <= bus.A;
            acc_q   <= {1'b0, {N{1'b0}}, bus.B};
            cnt_q   <= '0;
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_step_d) begin
            p_q     <= acc_d[2*N-1:0];
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.P    = p_q;
endmodule
